// File: rtl/la_capture_ctrl_pkg.sv
// rtl/la_capture_ctrl_pkg.sv - shared constants and state encodings for the logic-analyzer capture sequencer
package la_capture_ctrl_pkg;

    localparam int LA_DATA_WIDTH = 8;

    // Encodings are shared with the host read-out logic; keep them stable.
    localparam logic [2:0] LA_IDLE   = 3'd0;
    localparam logic [2:0] LA_FILL   = 3'd1;
    localparam logic [2:0] LA_PRIMED = 3'd2;
    localparam logic [2:0] LA_POST   = 3'd3;
    localparam logic [2:0] LA_DONE   = 3'd4;

    function automatic logic la_is_busy(input logic [2:0] s);
        return (s == LA_FILL) || (s == LA_PRIMED) || (s == LA_POST);
    endfunction

endpackage

// File: rtl/la_capture_ctrl.sv
// rtl/la_capture_ctrl.sv - capture sequencer: pre-trigger fill, primed wait, post-trigger fill into a circular sample RAM
module la_capture_ctrl
    import la_capture_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = LA_DATA_WIDTH,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] pretrig_len,
    input  logic                  trigger,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  primed,
    output logic                  busy,
    output logic                  done,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [ADDR_WIDTH-1:0] trig_addr,
    output logic [ADDR_WIDTH-1:0] start_addr
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);

    logic [2:0]            state;
    logic [2:0]            state_nxt;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0] plen;
    logic [ADDR_WIDTH-1:0] trig_ptr;
    logic [ADDR_WIDTH-1:0] post_len;
    logic [ADDR_WIDTH-1:0] trig_sel;
    logic                  writing;
    logic                  start;
    logic                  finish;

    // An ADDR_WIDTH-bit length can never exceed DEPTH-1, so the clamp is implicit.
    assign post_len = ADDR_MAX - plen;
    assign trig_sel = (state == LA_PRIMED) ? ptr : trig_ptr;
    assign finish   = (state_nxt == LA_DONE) && (state != LA_DONE);

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        writing   = 1'b0;
        case (state)
            LA_IDLE, LA_DONE: begin
                if (arm && !abort) begin
                    start     = 1'b1;
                    state_nxt = (pretrig_len == '0) ? LA_PRIMED : LA_FILL;
                end
            end
            LA_FILL: begin
                if (abort) begin
                    state_nxt = LA_IDLE;
                end else begin
                    writing = 1'b1;
                    if (cnt == ONE) state_nxt = LA_PRIMED;
                end
            end
            LA_PRIMED: begin
                if (abort) begin
                    state_nxt = LA_IDLE;
                end else begin
                    writing = 1'b1;
                    if (trigger) state_nxt = (post_len == '0) ? LA_DONE : LA_POST;
                end
            end
            LA_POST: begin
                if (abort) begin
                    state_nxt = LA_IDLE;
                end else begin
                    writing = 1'b1;
                    if (cnt == ONE) state_nxt = LA_DONE;
                end
            end
            default: state_nxt = LA_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= LA_IDLE;
            primed     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            trig_addr  <= '0;
            start_addr <= '0;
            ptr        <= '0;
            cnt        <= '0;
            plen       <= '0;
            trig_ptr   <= '0;
        end else begin
            state  <= state_nxt;
            busy   <= la_is_busy(state_nxt);
            primed <= (state_nxt == LA_PRIMED);
            wr_en  <= writing;
            if (writing) begin
                wr_addr <= ptr;
                wr_data <= data;
                ptr     <= ptr + ONE;
            end
            if (start) begin
                plen <= pretrig_len;
                cnt  <= pretrig_len;
                ptr  <= '0;
                done <= 1'b0;
            end
            case (state)
                LA_FILL: if (writing) cnt <= cnt - ONE;
                LA_PRIMED: begin
                    if (writing && trigger) begin
                        trig_ptr <= ptr;
                        cnt      <= post_len;
                    end
                end
                LA_POST: if (writing) cnt <= cnt - ONE;
                default: ;
            endcase
            // Report addresses only on completion so an abort leaves the last capture's results intact.
            if (finish) begin
                done       <= 1'b1;
                trig_addr  <= trig_sel;
                start_addr <= trig_sel - plen;
            end
        end
    end

endmodule

// File: tb/tb_la_capture_ctrl.sv
// tb/tb_la_capture_ctrl.sv - scoreboard bench for la_capture_ctrl with a sample-index reference model
module tb_la_capture_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          arm = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] pretrig_len = '0;
    logic          trigger = 1'b0;
    logic [DW-1:0] data = '0;
    logic          primed, busy, done, wr_en;
    logic [AW-1:0] wr_addr, trig_addr, start_addr;
    logic [DW-1:0] wr_data;

    la_capture_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .arm(arm), .abort(abort),
        .pretrig_len(pretrig_len), .trigger(trigger), .data(data),
        .primed(primed), .busy(busy), .done(done), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .trig_addr(trig_addr), .start_addr(start_addr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    int            checks = 0;
    int            errors = 0;
    wr_t           exp_wr[$];
    logic [AW-1:0] exp_trig[$];
    logic [AW-1:0] exp_start[$];
    logic [AW-1:0] last_trig = '0;
    logic [AW-1:0] last_start = '0;
    logic          done_prev = 1'b0;
    wr_t           mon_e;
    logic [AW-1:0] mon_a;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (wr_en) begin
            if (exp_wr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual_addr=%0d required=no_write", wr_addr);
            end else begin
                mon_e = exp_wr.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
                check("wr_data", 32'(wr_data), 32'(mon_e.data));
            end
        end
        if (done && !done_prev) begin
            if (exp_trig.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                mon_a = exp_trig.pop_front();
                check("trig_addr", 32'(trig_addr), 32'(mon_a));
                mon_a = exp_start.pop_front();
                check("start_addr", 32'(start_addr), 32'(mon_a));
            end
        end
        done_prev = done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_primed"}, 32'(primed), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_wr_en"}, 32'(wr_en), 0);
        check({tag, "_wr_addr"}, 32'(wr_addr), 0);
        check({tag, "_wr_data"}, 32'(wr_data), 0);
        check({tag, "_trig_addr"}, 32'(trig_addr), 0);
        check({tag, "_start_addr"}, 32'(start_addr), 0);
    endtask

    // Sample k (k=0 is the cycle after arm) lands at address k mod DEPTH. The first sample at or
    // after index p with trigger high is the trigger; capture ends DEPTH-1-p samples later.
    task automatic run_capture(input int p, input int t, input int abort_at, input int reset_at,
                               input bit fill_hi);
        int            n;
        int            w;
        logic [DW-1:0] d;
        wr_t           e;
        n = t + 1 + (DEPTH - 1 - p);
        pretrig_len = AW'(p);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int k = 0; k < n; k++) begin
            check("primed", 32'(primed), 32'((k >= p) && (k <= t)));
            check("busy", 32'(busy), 1);
            if (k == abort_at) begin
                abort = 1'b1;
                trigger = 1'b0;
                tick();
                abort = 1'b0;
                check("abort_busy", 32'(busy), 0);
                check("abort_wr_en", 32'(wr_en), 0);
                check("abort_done", 32'(done), 0);
                check("abort_primed", 32'(primed), 0);
                check("abort_trig_addr", 32'(trig_addr), 32'(last_trig));
                check("abort_start_addr", 32'(start_addr), 32'(last_start));
                repeat (4) tick();
                check("abort_idle_busy", 32'(busy), 0);
                return;
            end
            if (k == reset_at) begin
                reset = 1'b0;
                #1;
                check_all_zero("midreset");
                exp_wr.delete();
                exp_trig.delete();
                exp_start.delete();
                last_trig = '0;
                last_start = '0;
                tick();
                tick();
                check_all_zero("held_reset");
                reset = 1'b1;
                tick();
                return;
            end
            d = DW'($urandom);
            data = d;
            if (k < p)       trigger = fill_hi ? 1'b1 : 1'($urandom);
            else if (k < t)  trigger = 1'b0;
            else if (k == t) trigger = 1'b1;
            else             trigger = 1'($urandom);
            e.addr = AW'(k);
            e.data = d;
            exp_wr.push_back(e);
            if (k == n - 1) begin
                last_trig = AW'(t);
                last_start = AW'(t - p);
                exp_trig.push_back(last_trig);
                exp_start.push_back(last_start);
            end
            tick();
        end
        trigger = 1'b0;
        w = 0;
        while (!done && w < 40) begin
            tick();
            w++;
        end
        check("done", 32'(done), 1);
        check("done_busy", 32'(busy), 0);
        check("done_primed", 32'(primed), 0);
        tick();
        tick();
        check("writes_drained", 32'(exp_wr.size()), 0);
        check("done_wr_en", 32'(wr_en), 0);
        check("done_held", 32'(done), 1);
    endtask

    initial begin
        int p;
        int t;
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b1;
        tick();

        run_capture(4, 13, -1, -1, 1'b0);
        run_capture(0, 0, -1, -1, 1'b0);
        run_capture(6, 6, -1, -1, 1'b1);

        pretrig_len = AW'(3);
        arm = 1'b1;
        abort = 1'b1;
        tick();
        arm = 1'b0;
        abort = 1'b0;
        check("arm_abort_busy", 32'(busy), 0);
        repeat (4) tick();
        check("arm_abort_done", 32'(done), 1);
        check("arm_abort_wr_en", 32'(wr_en), 0);

        run_capture(2, 40, 20, -1, 1'b0);
        run_capture(3, 9, -1, -1, 1'b0);
        run_capture(5, 10, -1, 14, 1'b0);
        run_capture(7, 12, -1, -1, 1'b0);
        run_capture(15, 20, -1, -1, 1'b0);
        run_capture(15, 15, -1, -1, 1'b1);

        for (int i = 0; i < 10; i++) begin
            p = int'($urandom_range(0, DEPTH - 1));
            t = p + int'($urandom_range(0, 25));
            run_capture(p, t, -1, -1, 1'b0);
        end

        check("final_wr_queue", 32'(exp_wr.size()), 0);
        check("final_done_queue", 32'(exp_trig.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
